// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus shared by the execution units: one valid/ready lane
// per requester, with destination and data packed requester-major.
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int RA_W    = 5
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*RA_W-1:0] req_rd;
  logic [NUM_REQ*XLEN-1:0] req_data;

  modport master (output req_valid, output req_rd, output req_data, input req_ready);
  modport slave  (input req_valid, input req_rd, input req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file write port, with a registered
// output stage and a pending-write scoreboard for RAW hazard detection.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int RA_W    = 5
) (
  input  logic                clk,
  input  logic                reset,
  regfile_wb_arbiter_if.slave wb,
  input  logic                issue_valid,
  input  logic [RA_W-1:0]     issue_rd,
  input  logic [RA_W-1:0]     hz_rs1,
  input  logic [RA_W-1:0]     hz_rs2,
  output logic                hz_busy1,
  output logic                hz_busy2,
  output logic                rf_reg_write,
  output logic [RA_W-1:0]     rf_write_reg,
  output logic [XLEN-1:0]     rf_write_data,
  output logic [1:0]          grant_id,
  output logic [15:0]         stall_cycles
);
  localparam int NREGS = 1 << RA_W;

  logic [1:0]         ptr_q, ptr_d;
  logic [NREGS-1:0]   busy_q, busy_d;
  logic               rf_reg_write_q, rf_reg_write_d;
  logic [RA_W-1:0]    rf_write_reg_q, rf_write_reg_d;
  logic [XLEN-1:0]    rf_write_data_q, rf_write_data_d;
  logic [1:0]         grant_id_q, grant_id_d;
  logic [15:0]        stall_q, stall_d;

  logic               hit_s;
  logic [1:0]         gnt_s;
  logic [2:0]         sum_s;
  logic [NUM_REQ-1:0] ready_s;
  logic [RA_W-1:0]    sel_rd_s;
  logic [XLEN-1:0]    sel_data_s;
  logic               unserved_s;

  // Winner search: first valid requester at or after the pointer, wrapping
  always_comb begin
    hit_s = 1'b0;
    gnt_s = 2'd0;
    sum_s = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = {1'b0, ptr_q} + 3'(k);
      if (sum_s >= 3'(NUM_REQ)) begin
        sum_s = sum_s - 3'(NUM_REQ);
      end else begin
        sum_s = sum_s;
      end
      if (!hit_s && wb.req_valid[sum_s[1:0]]) begin
        hit_s = 1'b1;
        gnt_s = sum_s[1:0];
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Grant decode is suppressed while reset is held so nothing is accepted then
  always_comb begin
    if (reset && hit_s) begin
      ready_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_s;
    end else begin
      ready_s = {NUM_REQ{1'b0}};
    end
    sel_rd_s   = wb.req_rd[gnt_s*RA_W +: RA_W];
    sel_data_s = wb.req_data[gnt_s*XLEN +: XLEN];
    unserved_s = |(wb.req_valid & ~ready_s);
  end

  // Next-state for output stage, pointer and stall counter
  always_comb begin
    rf_write_reg_d  = rf_write_reg_q;
    rf_write_data_d = rf_write_data_q;
    grant_id_d      = grant_id_q;
    ptr_d           = ptr_q;
    rf_reg_write_d  = 1'b0;
    if (|ready_s) begin
      rf_write_reg_d  = sel_rd_s;
      rf_write_data_d = sel_data_s;
      grant_id_d      = gnt_s;
      rf_reg_write_d  = (sel_rd_s != {RA_W{1'b0}});
      if (gnt_s == 2'(NUM_REQ - 1)) begin
        ptr_d = 2'd0;
      end else begin
        ptr_d = gnt_s + 2'd1;
      end
    end else begin
      rf_reg_write_d = 1'b0;
    end
    if (unserved_s && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Scoreboard: clear on commit first, so a same-edge issue to that register wins
  always_comb begin
    busy_d = busy_q;
    if (rf_reg_write_q) begin
      busy_d[rf_write_reg_q] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (issue_valid && (issue_rd != {RA_W{1'b0}})) begin
      busy_d[issue_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q           <= 2'd0;
      busy_q          <= {NREGS{1'b0}};
      rf_reg_write_q  <= 1'b0;
      rf_write_reg_q  <= {RA_W{1'b0}};
      rf_write_data_q <= {XLEN{1'b0}};
      grant_id_q      <= 2'd0;
      stall_q         <= 16'd0;
    end else begin
      ptr_q           <= ptr_d;
      busy_q          <= busy_d;
      rf_reg_write_q  <= rf_reg_write_d;
      rf_write_reg_q  <= rf_write_reg_d;
      rf_write_data_q <= rf_write_data_d;
      grant_id_q      <= grant_id_d;
      stall_q         <= stall_d;
    end
  end

  assign wb.req_ready    = ready_s;
  assign hz_busy1        = busy_q[hz_rs1];
  assign hz_busy2        = busy_q[hz_rs2];
  assign rf_reg_write    = rf_reg_write_q;
  assign rf_write_reg    = rf_write_reg_q;
  assign rf_write_data   = rf_write_data_q;
  assign grant_id        = grant_id_q;
  assign stall_cycles    = stall_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed and randomized checks of regfile_wb_arbiter against a cycle-level
// behavioural model of the arbitration and scoreboard rules.
module tb_regfile_wb_arbiter;
  localparam int NR = 3;
  localparam int XW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid;
  logic [RW-1:0] issue_rd, hz_rs1, hz_rs2;
  logic          hz_busy1, hz_busy2, rf_reg_write;
  logic [RW-1:0] rf_write_reg;
  logic [XW-1:0] rf_write_data;
  logic [1:0]    grant_id;
  logic [15:0]   stall_cycles;

  regfile_wb_arbiter_if #(.NUM_REQ(NR), .XLEN(XW), .RA_W(RW)) wb ();

  regfile_wb_arbiter #(.NUM_REQ(NR), .XLEN(XW), .RA_W(RW)) dut (
    .clk(clk), .reset(reset), .wb(wb),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .hz_rs1(hz_rs1), .hz_rs2(hz_rs2),
    .hz_busy1(hz_busy1), .hz_busy2(hz_busy2),
    .rf_reg_write(rf_reg_write), .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data), .grant_id(grant_id),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int          m_ptr = 0;
  bit [31:0]   m_busy = '0;
  bit          m_we = 1'b0;
  int          m_wr = 0;
  logic [31:0] m_wd = '0;
  int          m_gid = 0;
  int          m_stall = 0;
  int          last_win = -1;
  bit          pending [NR];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner();
    int i;
    if (!reset) return -1;
    for (int k = 0; k < NR; k++) begin
      i = (m_ptr + k) % NR;
      if (wb.req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_req(int i, logic v, logic [RW-1:0] rd, logic [XW-1:0] d);
    wb.req_valid[i]       = v;
    wb.req_rd[i*RW +: RW] = rd;
    wb.req_data[i*XW +: XW] = d;
  endtask

  // Called at a negedge with this cycle's inputs already driven.
  task automatic cycle();
    int w;
    logic [NR-1:0] er;
    bit unserved;
    bit [31:0] nb;
    #1;
    w = model_winner();
    last_win = w;
    er = (w >= 0) ? NR'(1 << w) : '0;
    chk("req_ready", 32'(wb.req_ready), 32'(er));
    chk("hz_busy1", 32'(hz_busy1), 32'(m_busy[hz_rs1]));
    chk("hz_busy2", 32'(hz_busy2), 32'(m_busy[hz_rs2]));
    if (!reset) begin
      m_ptr = 0; m_busy = '0; m_we = 0; m_wr = 0; m_wd = '0; m_gid = 0; m_stall = 0;
    end else begin
      unserved = 0;
      for (int i = 0; i < NR; i++) if (wb.req_valid[i] && i != w) unserved = 1;
      if (unserved && m_stall < 65535) m_stall++;
      nb = m_busy;
      if (m_we) nb[m_wr] = 1'b0;
      if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
      m_busy = nb;
      if (w >= 0) begin
        m_wr  = int'(wb.req_rd[w*RW +: RW]);
        m_wd  = wb.req_data[w*XW +: XW];
        m_we  = (m_wr != 0);
        m_gid = w;
        m_ptr = (w + 1) % NR;
      end else begin
        m_we = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("rf_reg_write", 32'(rf_reg_write), 32'(m_we));
    chk("rf_write_reg", 32'(rf_write_reg), 32'(m_wr));
    chk("rf_write_data", rf_write_data, m_wd);
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    issue_valid = 1'b0; issue_rd = '0; hz_rs1 = 5'd1; hz_rs2 = 5'd2;
    set_req(0, 1'b1, 5'd1, 32'h1111_0000);
    set_req(1, 1'b1, 5'd2, 32'h2222_0000);
    set_req(2, 1'b1, 5'd3, 32'h3333_0000);
    @(negedge clk);

    // reset held with all requesters valid
    cycle(); cycle();
    chk("rst_stall", 32'(stall_cycles), 32'd0);

    // continuous contention: grants rotate 0,1,2,0,...
    reset = 1'b1;
    cycle();
    chk("first_gid", 32'(grant_id), 32'd0);
    for (int n = 0; n < 6; n++) cycle();

    // write to x0 from requester 2 only
    set_req(0, 1'b0, 5'd1, 32'h0); set_req(1, 1'b0, 5'd2, 32'h0);
    set_req(2, 1'b1, 5'd0, 32'hDEAD_BEEF);
    cycle();
    chk("x0_gid", 32'(grant_id), 32'd2);
    chk("x0_we", 32'(rf_reg_write), 32'd0);

    // RAW on x5: issue, wait, then requester 1 writes it
    set_req(2, 1'b0, 5'd0, 32'h0);
    hz_rs1 = 5'd5; issue_valid = 1'b1; issue_rd = 5'd5;
    cycle();
    issue_valid = 1'b0;
    cycle();
    chk("x5_busy", 32'(hz_busy1), 32'd1);
    cycle();
    set_req(1, 1'b1, 5'd5, 32'h0000_1234);
    cycle();
    set_req(1, 1'b0, 5'd5, 32'h0000_1234);
    cycle();
    chk("x5_clear", 32'(hz_busy1), 32'd0);

    // set wins over commit-clear on x7
    hz_rs2 = 5'd7; issue_valid = 1'b1; issue_rd = 5'd7;
    cycle();
    issue_valid = 1'b0;
    set_req(0, 1'b1, 5'd7, 32'h0000_0077);
    cycle();
    set_req(0, 1'b0, 5'd7, 32'h0);
    issue_valid = 1'b1; issue_rd = 5'd7;
    cycle();
    chk("x7_kept", 32'(hz_busy2), 32'd1);
    issue_valid = 1'b0;

    // reset right after a handshake loses the write and rewinds the pointer
    set_req(1, 1'b1, 5'd9, 32'h0000_0099);
    cycle();
    set_req(1, 1'b0, 5'd9, 32'h0);
    reset = 1'b0;
    cycle();
    chk("rst_we", 32'(rf_reg_write), 32'd0);
    reset = 1'b1;
    set_req(0, 1'b1, 5'd1, 32'hA); set_req(1, 1'b1, 5'd2, 32'hB); set_req(2, 1'b1, 5'd3, 32'hC);
    cycle();
    chk("rst_ptr_gid", 32'(grant_id), 32'd0);
    for (int i = 0; i < NR; i++) pending[i] = 1'b1;
    if (last_win >= 0) pending[last_win] = 1'b0;

    // randomized traffic; requesters hold their request until granted
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pending[i] && ($urandom_range(0, 1) == 1)) begin
          pending[i] = 1'b1;
          set_req(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
        end else begin
          wb.req_valid[i] = pending[i];
        end
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd = 5'($urandom_range(0, 31));
      hz_rs1 = 5'($urandom_range(0, 31));
      hz_rs2 = ($urandom_range(0, 1) == 1) ? rf_write_reg : 5'($urandom_range(0, 31));
      reset = ($urandom_range(0, 63) != 0);
      cycle();
      if (last_win >= 0) pending[last_win] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
